ps2_frame_rx: RTL
=================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, giving the consecutive clk cycles a synchronized kbdclk level must hold before it is accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum clk cycles between accepted kbdclk falling edges inside a frame.
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; it is the only clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port kbdclk, input, 1 bit, the asynchronous PS/2 clock line.
REQ-006 The block SHALL have port kbddat, input, 1 bit, the asynchronous PS/2 data line.
REQ-007 The block SHALL have port code, output, 8 bits, the last correctly received scan code byte.
REQ-008 The block SHALL have port code_valid, output, 1 bit, a one-cycle pulse when code is updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse when a frame is rejected.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.

Function
REQ-011 kbdclk and kbddat SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Filtered kbdclk SHALL change level only after the synchronized kbdclk has differed from it for FILTER_LEN consecutive cycles; shorter glitches SHALL be ignored.
REQ-013 A falling-edge strobe SHALL assert for exactly 1 cycle (cycle N) when filtered kbdclk goes 1->0; synchronized kbddat is sampled in that cycle.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-015 IDLE: on strobe with sampled data 0 (start bit), clear the bit counter and go to DATA; with sampled data 1, stay in IDLE with no output.
REQ-016 DATA: on each strobe, shift the sampled bit in LSB-first; after the 8th bit (counter 0..7), go to PARITY.
REQ-017 PARITY: on strobe, store the parity bit and go to STOP.
REQ-018 STOP: on strobe, the frame is good if stop=1 and the 8 data bits plus parity hold an odd count of ones.
REQ-019 Good frame: in cycle N+1, code SHALL load the byte and code_valid SHALL pulse high for 1 cycle.
REQ-020 Bad frame: in cycle N+1, frame_err SHALL pulse high for 1 cycle and code SHALL stay unchanged.
REQ-021 In both the good and bad case, the FSM SHALL return to IDLE.
REQ-022 Timeout counter: cleared on every strobe and while in IDLE, incremented otherwise, saturating.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES outside IDLE, the block SHALL pulse frame_err for 1 cycle, go to IDLE and discard the partial byte.
REQ-024 code_valid and frame_err SHALL never be high in the same cycle.
REQ-025 Back-to-back frames SHALL be accepted with no idle gap beyond the PS/2 stop-bit timing.

Reset
REQ-026 While rst_n=0, the block SHALL hold: state IDLE, code=8'h00, code_valid=0, frame_err=0, busy=0, bit counter 0, timeout counter 0.
REQ-027 While rst_n=0, the filtered kbdclk and all synchronizer flops SHALL be held at 1 (idle line level), so releasing reset with kbdclk high produces no strobe.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no code_valid or frame_err pulse; the first frame after release SHALL decode normally.

Verification (bench: FILTER_LEN=4, TIMEOUT_CYCLES=2000, kbdclk half-period 200 cycles, data changed at kbdclk high midpoint)
REQ-029 Frame 0x1C, parity 0, stop 1 -> code=8'h1C, one code_valid pulse 1 cycle after the 11th filtered falling edge, frame_err never high, busy low afterwards.
REQ-030 Frame 0x1C with parity 1 -> one frame_err pulse, code keeps its previous value, no code_valid.
REQ-031 Frame 0xF0, parity 1, stop bit 0 -> one frame_err pulse, no code_valid, FSM in IDLE.
REQ-032 A 2-cycle low glitch on kbdclk in IDLE, then frame 0x32 -> glitch ignored, code=8'h32 with one code_valid.
REQ-033 Stop kbdclk after 4 data bits -> frame_err 2000 cycles after the last strobe, busy falls; following frame 0x1C -> code=8'h1C.
REQ-034 rst_n low for 3 cycles after bit 5 of a frame -> outputs zero, no pulses; the next full frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and flags bad or stalled frames.
module ps2_frame_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kbdclk,
   input  logic       kbddat,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic           r_clk_s1, r_clk_s2;
   logic           r_dat_s1, r_dat_s2;
   logic           r_clk_filt, r_clk_filt_d;
   logic [FCW-1:0] r_filt_cnt;
   logic [1:0]     r_state;
   logic [2:0]     r_bit_cnt;
   logic [7:0]     r_shift;
   logic           r_parity;
   logic [TCW-1:0] r_to_cnt;
   logic           w_strobe;
   logic           w_timeout;

   // Synchronizers park at the idle line level so reset release never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= kbdclk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= kbddat;
         r_dat_s2 <= r_dat_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_filt_cnt   <= '0;
      end else begin
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_s2 != r_clk_filt) begin
            if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
               r_clk_filt <= r_clk_s2;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + 1'b1;
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_strobe  = r_clk_filt_d & ~r_clk_filt;
   // A strobe in the same cycle as expiry means the line is still alive, so it wins.
   assign w_timeout = (r_state != S_IDLE) && !w_strobe && (r_to_cnt >= TCW'(TIMEOUT_CYCLES));
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_to_cnt   <= '0;
         code       <= 8'h00;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (r_state == S_IDLE || w_strobe) begin
            r_to_cnt <= '0;
         end else if (!(&r_to_cnt)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (w_timeout) begin
            frame_err <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
         end else if (w_strobe) begin
            case (r_state)
               S_IDLE: begin
                  if (!r_dat_s2) begin
                     r_bit_cnt <= '0;
                     r_state   <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  r_parity <= r_dat_s2;
                  r_state  <= S_STOP;
               end
               S_STOP: begin
                  // Odd parity: reduction XOR over data plus parity must be 1.
                  if (r_dat_s2 && (^{r_shift, r_parity})) begin
                     code       <= r_shift;
                     code_valid <= 1'b1;
                  end else begin
                     frame_err  <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
